// File: rtl/trivium_pkg.sv
// Shared widths and bit-placement helper for the Trivium keystream byte path.
package trivium_pkg;

    localparam int BYTE_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    // Bit position inside a byte for the pos-th keystream bit; MSB-first mirrors it.
    function automatic int unsigned ins_idx(input int unsigned pos,
                                            input int unsigned width,
                                            input bit          lsb_first);
        return lsb_first ? pos : (width - 1 - pos);
    endfunction

endpackage

// File: rtl/trivium_ks_packer.sv
// Steps the keystream generator, packs its serial bits into bytes and
// double-buffers them (accumulator + hold register) for the XOR stage.
module trivium_ks_packer
    import trivium_pkg::*;
#(
    parameter int BYTE_W    = BYTE_W_DEF,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    output logic              ks_en,
    input  logic              ks_bit,
    input  logic              ks_vld,
    input  logic              hold_take,
    output logic [BYTE_W-1:0] hold_byte,
    output logic              hold_full
);

    localparam int CW = $clog2(BYTE_W + 1);
    localparam int IW = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
    localparam logic [CW:0] FULL = (CW + 1)'(BYTE_W);

    logic [BYTE_W-1:0] acc_q, acc_d, hold_q, hold_d;
    logic [CW-1:0]     acc_cnt_q, acc_cnt_d, pos;
    logic              hold_full_q, hold_full_d;
    logic              ks_pend_q;
    logic              capture, move;
    logic [CW:0]       fill;
    logic [IW-1:0]     idx;

    // Stop stepping once an in-flight bit could no longer find a slot.
    assign fill    = {1'b0, acc_cnt_q} + (CW + 1)'(ks_pend_q);
    assign ks_en   = !rst && !clear && !(hold_full_q && (fill >= FULL));
    assign capture = ks_pend_q && ks_vld && !clear;
    assign move    = (acc_cnt_q == CW'(BYTE_W)) && (!hold_full_q || hold_take);
    assign pos     = move ? '0 : acc_cnt_q;
    assign idx     = IW'(ins_idx(32'(pos), BYTE_W, LSB_FIRST));

    always_comb begin
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (clear) begin
            acc_d       = '0;
            acc_cnt_d   = '0;
            hold_d      = '0;
            hold_full_d = 1'b0;
        end else begin
            if (move) begin
                hold_d      = acc_q;
                hold_full_d = 1'b1;
                acc_d       = '0;
                acc_cnt_d   = '0;
            end else if (hold_take) begin
                hold_full_d = 1'b0;
            end
            if (capture && (move || (acc_cnt_q < CW'(BYTE_W)))) begin
                acc_d[idx] = ks_bit;
                acc_cnt_d  = acc_cnt_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ks_pend_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ks_pend_q   <= ks_en;
        end
    end

    assign hold_byte = hold_q;
    assign hold_full = hold_full_q;

endmodule

// File: rtl/trivium_byte_xor.sv
// XORs a byte stream with packed Trivium keystream under valid/ready
// handshakes; one registered output byte and a wrapping transfer counter.
module trivium_byte_xor
    import trivium_pkg::*;
#(
    parameter int BYTE_W    = BYTE_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    output logic              ks_en,
    input  logic              ks_bit,
    input  logic              ks_vld,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  byte_count
);

    logic [BYTE_W-1:0] hold_byte;
    logic              hold_full, hold_take;
    logic              out_valid_q, out_valid_d;
    logic [BYTE_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    trivium_ks_packer #(
        .BYTE_W    (BYTE_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_pack (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .ks_en     (ks_en),
        .ks_bit    (ks_bit),
        .ks_vld    (ks_vld),
        .hold_take (hold_take),
        .hold_byte (hold_byte),
        .hold_full (hold_full)
    );

    // Accept while the output slot is free or draining this cycle.
    assign in_ready  = hold_full && (!out_valid_q || out_ready);
    assign hold_take = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cnt_d       = cnt_q;
        if (clear) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            cnt_d       = '0;
        end else if (hold_take) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data ^ hold_byte;
            cnt_d       = cnt_q + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_trivium_byte_xor.sv
// Directed bench for trivium_byte_xor: a behavioural keystream source plus a
// byte scoreboard, table vectors and hand-written multi-cycle sequences.
module tb_trivium_byte_xor;

    logic       clk = 1'b0, rst = 1'b1, clear = 1'b0;
    logic       ks_bit = 1'b0, ks_vld = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       ks_en, in_ready, out_valid;
    logic [7:0] out_data;
    logic [15:0] byte_count;
    logic       ks_en4, in_ready4, out_valid4;
    logic [7:0] out_data4;
    logic [3:0] byte_count4;

    trivium_byte_xor dut (
        .clk(clk), .rst(rst), .clear(clear), .ks_en(ks_en), .ks_bit(ks_bit), .ks_vld(ks_vld),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .byte_count(byte_count)
    );

    // Same stimulus, narrow counter so the wrap is reachable quickly.
    trivium_byte_xor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .clear(clear), .ks_en(ks_en4), .ks_bit(ks_bit), .ks_vld(ks_vld),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4), .out_valid(out_valid4),
        .out_data(out_data4), .out_ready(out_ready), .byte_count(byte_count4)
    );

    always #5 clk = ~clk;

    int          tests = 0, fails = 0;
    int          warm_left = 0, ph = 0, nxfer = 0, cyc = 0;
    int unsigned vcnt = 0;
    bit          mode = 1'b0, xfer_seen = 1'b0;
    logic [7:0]  pat = 8'h00;
    bit          exp_bits[$];
    logic [7:0]  exp_out[$];

    typedef struct {
        logic [7:0] pat;
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;
    vec_t tv[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit src();
        logic [31:0] x;
        logic [7:0]  p;
        x = vcnt * 32'h9E3779B1;
        p = pat;
        return mode ? (x[17] ^ x[29] ^ x[5]) : p[ph[2:0]];
    endfunction

    task automatic gen_update(input logic en);
        if (en) begin
            if (warm_left > 0) begin
                ks_vld = 1'b0;
                ks_bit = 1'($urandom_range(0, 1));
                warm_left--;
            end else begin
                ks_vld = 1'b1;
                ks_bit = src();
                exp_bits.push_back(ks_bit);
                vcnt++;
                ph++;
            end
        end else begin
            ks_bit = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic pop_byte(output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (exp_bits.size() == 0) begin
                tests++; fails++;
                $display("FAIL ks_model_underflow: got %0d bits expected 8", i);
                return;
            end
            b[i] = exp_bits.pop_front();
        end
    endtask

    task automatic step();
        logic       en, xf;
        logic [7:0] xd, e;
        @(negedge clk);
        en = ks_en;
        xf = in_valid && in_ready && !rst && !clear;
        xd = in_data;
        if (out_valid && out_ready && !rst && !clear) begin
            if (exp_out.size() == 0) begin
                tests++; fails++;
                $display("FAIL sb_unexpected: got %0h expected no byte", out_data);
            end else begin
                e = exp_out.pop_front();
                chk("sb_out_data", 32'(out_data), 32'(e));
            end
        end
        @(posedge clk); #1;
        cyc++;
        gen_update(en);
        if (xf) begin
            pop_byte(e);
            exp_out.push_back(xd ^ e);
            nxfer++;
            chk("byte_count", 32'(byte_count), 32'(nxfer & 32'hFFFF));
            chk("byte_count_w4", 32'(byte_count4), 32'(nxfer & 15));
        end
        xfer_seen = xf;
    endtask

    task automatic flush_model();
        exp_bits.delete();
        exp_out.delete();
        ph = 0;
        nxfer = 0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        flush_model();
        step();
        clear = 1'b0;
    endtask

    task automatic wait_xfer(input string nm);
        xfer_seen = 1'b0;
        for (int i = 0; i < 200 && !xfer_seen; i++) step();
        if (!xfer_seen) begin
            tests++; fails++;
            $display("FAIL %s_timeout: got no transfer expected one within 200 cycles", nm);
        end
    endtask

    task automatic get_byte(input logic [7:0] d, output logic [7:0] o);
        in_data = d; in_valid = 1'b1; out_ready = 1'b1;
        wait_xfer("get_byte");
        in_valid = 1'b0;
        o = out_data;
        step();
    endtask

    initial begin
        logic [7:0] o, held;
        int         last_cyc, ok;
        bit         stable;

        tv[0] = '{8'h8D, 8'h00, 8'h8D};
        tv[1] = '{8'hA5, 8'h3C, 8'h99};
        tv[2] = '{8'hA5, 8'h99, 8'h3C};
        tv[3] = '{8'h0F, 8'hFF, 8'hF0};
        tv[4] = '{8'h34, 8'h12, 8'h26};

        // Reset state
        step(); step();
        chk("rst_ks_en", 32'(ks_en), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_byte_count", 32'(byte_count), 0);

        // Warm-up: 20 ignored bits, then 1,0,1,1,0,0,0,1
        mode = 1'b0; pat = 8'h8D; warm_left = 20; flush_model();
        rst = 1'b0; out_ready = 1'b1;
        repeat (5) step();
        chk("warm_ks_en", 32'(ks_en), 1);
        chk("warm_acc_cnt", 32'(dut.u_pack.acc_cnt_q), 0);
        get_byte(8'h00, o);
        chk("warm_out_data", 32'(o), 32'h8D);
        chk("warm_byte_count", 32'(byte_count), 1);

        // Table vectors (clear whenever the keystream pattern changes)
        for (int i = 0; i < 5; i++) begin
            if (i == 0 || tv[i].pat != tv[i-1].pat) begin
                pat = tv[i].pat;
                do_clear();
            end
            get_byte(tv[i].din, o);
            chk("vec_out_data", 32'(o), 32'(tv[i].dout));
        end

        // Throughput and counter wrap
        pat = 8'h5A; do_clear();
        in_valid = 1'b1; out_ready = 1'b1; last_cyc = 0;
        for (int i = 0; i < 400 && nxfer < 18; i++) begin
            in_data = 8'(nxfer * 7);
            step();
            if (xfer_seen) begin
                if (nxfer > 1) chk("tput_gap", 32'(cyc - last_cyc), 8);
                last_cyc = cyc;
            end
        end
        in_valid = 1'b0; step();
        chk("tput_count", 32'(byte_count), 18);
        chk("tput_count_w4", 32'(byte_count4), 2);

        // Back-pressure with a non-repeating keystream
        mode = 1'b1; do_clear();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        wait_xfer("bp_first");
        held = out_data; stable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_data = 8'($urandom);
            step();
            if (out_data !== held) stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 1);
        chk("bp_out_valid", 32'(out_valid), 1);
        chk("bp_ks_en_low", 32'(ks_en), 0);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_nxfer", 32'(nxfer), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 400 && nxfer < 17; i++) begin
            in_data = 8'($urandom);
            step();
        end
        in_valid = 1'b0; step(); step();
        chk("bp_bytes", 32'(nxfer), 17);
        chk("bp_drained", 32'(exp_out.size()), 0);

        // Clear mid-byte with the hold register full
        do_clear();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h22;
        wait_xfer("clr_setup");
        in_valid = 1'b0; ok = 0;
        for (int i = 0; i < 100 && ok == 0; i++) begin
            step();
            if (dut.u_pack.hold_full_q && dut.u_pack.acc_cnt_q == 4'd5) ok = 1;
        end
        chk("clr_reached", 32'(ok), 1);
        chk("clr_pre_valid", 32'(out_valid), 1);
        do_clear();
        chk("clr_out_valid", 32'(out_valid), 0);
        chk("clr_byte_count", 32'(byte_count), 0);
        chk("clr_in_ready", 32'(in_ready), 0);
        chk("clr_acc_cnt", 32'(dut.u_pack.acc_cnt_q), 0);
        get_byte(8'h5A, o);

        // Reset mid-transfer
        mode = 1'b0; pat = 8'hC3; do_clear();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h33;
        wait_xfer("rst_setup");
        in_valid = 1'b0; ok = 0;
        for (int i = 0; i < 100 && ok == 0; i++) begin
            step();
            if (out_valid && dut.u_pack.acc_cnt_q == 4'd3) ok = 1;
        end
        chk("rst_reached", 32'(ok), 1);
        rst = 1'b1; flush_model();
        step();
        chk("rstm_ks_en", 32'(ks_en), 0);
        chk("rstm_in_ready", 32'(in_ready), 0);
        chk("rstm_out_valid", 32'(out_valid), 0);
        chk("rstm_out_data", 32'(out_data), 0);
        chk("rstm_byte_count", 32'(byte_count), 0);
        chk("rstm_acc_cnt", 32'(dut.u_pack.acc_cnt_q), 0);
        rst = 1'b0;
        step();
        chk("rstm_resume_acc", 32'(dut.u_pack.acc_cnt_q), 0);
        chk("rstm_resume_ks_en", 32'(ks_en), 1);
        get_byte(8'h00, o);
        chk("rstm_out_data_after", 32'(o), 32'hC3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trivium_byte_xor.md
Name: trivium_byte_xor

Overview:
- Downstream consumer of the Trivium keystream generator.
- Drives the generator's step enable and packs its serial keystream bits into bytes.
- XORs each keystream byte with a byte-wide data stream under valid/ready handshakes.
- Sits between the keystream generator and the chip's 8-bit I/O path, giving encrypt/decrypt (identical operation) at up to one byte per 8 cycles, limited by keystream rate.

Parameters:
- BYTE_W, 8: data and keystream packing width.
- CNT_W, 16: width of the processed-byte counter.
- LSB_FIRST, 1: 1 = first keystream bit lands in bit 0; 0 = first bit lands in bit BYTE_W-1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- clear  input  1  synchronous flush of all buffered keystream (pulse on re-key)
- ks_en  output  1  step enable to generator; one generator step per high cycle
- ks_bit  input  1  generator keystream bit, registered, result of ks_en one cycle earlier
- ks_vld  input  1  high when ks_bit is a post-warm-up keystream bit
- in_valid  input  1  data byte offered
- in_data  input  BYTE_W  plaintext/ciphertext byte
- in_ready  output  1  block accepts in_data this cycle
- out_valid  output  1  result byte held
- out_data  output  BYTE_W  in_data XOR keystream byte
- out_ready  input  1  sink accepts out_data
- byte_count  output  CNT_W  bytes transferred since reset/clear, wraps at 2^CNT_W

Behaviour:
- Reset (rst=1 at a clk edge):
  - ks_en=0, in_ready=0, out_valid=0, out_data=0, byte_count=0.
  - Accumulator empty (acc_cnt=0), hold register empty, ks_pend=0.
  - rst has priority over clear.
- ks_pend:
  - Registered copy of ks_en: 1 means a generator bit arrives this cycle.
  - A bit is captured only when ks_pend=1 and ks_vld=1.
  - Warm-up bits (ks_vld=0) are ignored and not counted.
- Accumulator:
  - BYTE_W-bit shift register plus acc_cnt (0..BYTE_W).
  - Each captured bit is inserted at position acc_cnt; with LSB_FIRST=0 the position is mirrored.
- Hold register:
  - One keystream byte plus hold_full flag.
  - When acc_cnt=BYTE_W and (hold empty, or hold consumed this cycle), the accumulator moves into hold and acc_cnt goes to 0.
  - A bit captured in that same cycle becomes bit 0 of the fresh accumulator (acc_cnt=1).
  - No valid bit is ever dropped except as stated under clear.
- Flow control:
  - ks_en = !rst && !clear && !(hold_full && (acc_cnt + ks_pend >= BYTE_W)).
  - This guarantees the accumulator never overflows.
  - During warm-up ks_en stays high continuously.
- Data path (1-cycle latency):
  - in_ready = hold_full && (!out_valid || out_ready).
  - Transfer on in_valid && in_ready: out_data <= in_data ^ hold, out_valid <= 1, hold emptied, byte_count += 1 (wraps).
  - out_valid falls after out_ready with no new transfer.
  - out_data is stable while out_valid && !out_ready.
  - A simultaneous out_ready and new transfer gives back-to-back output with no bubble.
- Clear (synchronous, rst=0):
  - Empties acc and hold, acc_cnt=0, out_valid=0, byte_count=0, ks_en=0 that cycle.
  - A bit arriving in the cycle after clear (ks_pend from before clear) is discarded.
  - Clear mid-byte or with a held output byte loses that data by design.
- State summary (derived from acc_cnt/hold_full/out_valid, no separate encoded FSM):
  - FILL: hold empty.
  - READY: hold full, accumulator refilling.
  - STALL: hold full, acc full, ks_en low.
  - All transitions are as defined above.

Decomposition:
- Shared package trivium_pkg: BYTE_W default, CNT_W default, and the function for bit-insert index (LSB_FIRST mirroring).
- One natural sub-module, trivium_ks_packer: ks_en/ks_pend logic, accumulator, hold register.
  - Exposes hold_byte, hold_full, hold_take.
  - Top-level does the XOR, output register and byte_count.

Test Plan:
- Warm-up: ks_vld=0 for 20 steps with ks_bit random, then bits 1,0,1,1,0,0,0,1 with ks_vld=1, in_data=8'h00 -> out_data=8'h8D (LSB_FIRST=1), byte_count=1, no warm-up bit packed.
- Round trip: keystream 8'hA5 repeated, in_data 8'h3C -> out_data 8'h99; feed 8'h99 with same keystream -> 8'h3C.
- Back-pressure: out_ready=0 for 30 cycles with in_valid=1 continuous -> out_data stable, ks_en falls once acc full and hold full, zero keystream bits lost (reference-model compare over 16 bytes after release).
- Throughput: ks_vld=1, in_valid=1, out_ready=1 always -> one out_valid every 8 cycles after first byte, byte_count increments by 1 per byte, wraps 16'hFFFF -> 0.
- Clear mid-byte: clear after 5 bits captured, with hold full -> out_valid=0, byte_count=0, next byte built from bits after the discarded pending bit.
- Reset mid-transfer: rst=1 while out_valid=1 and acc_cnt=3 -> next cycle all outputs 0, ks_en=0; resumes filling from acc_cnt=0 after rst release.
